// File: rtl/jtag_dtm_tap_if.sv
// Debug Module Interface (DMI) bundle between the JTAG DTM and a debug module.
//
// Signal suffixes are from the DTM's point of view: _o is driven by the DTM,
// _i is driven by the debug module.
//   dmi_req_valid_o / dmi_req_ready_i   request handshake
//   dmi_req_addr_o  [AddrWidth-1:0]     register address
//   dmi_req_data_o  [31:0]              write data
//   dmi_req_op_o    [1:0]               1 = read, 2 = write
//   dmi_resp_valid_i / dmi_resp_ready_o response handshake
//   dmi_resp_data_i [31:0]              read data
//   dmi_resp_resp_i [1:0]               0 = ok, 2 = failed
//
// Modports: master = DTM side, slave = debug module side.
interface jtag_dtm_tap_if #(
  parameter int unsigned AddrWidth = 7
);
  logic                 dmi_req_valid_o;
  logic                 dmi_req_ready_i;
  logic [AddrWidth-1:0] dmi_req_addr_o;
  logic [31:0]          dmi_req_data_o;
  logic [1:0]           dmi_req_op_o;
  logic                 dmi_resp_valid_i;
  logic                 dmi_resp_ready_o;
  logic [31:0]          dmi_resp_data_i;
  logic [1:0]           dmi_resp_resp_i;

  modport master (
    output dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o,
    output dmi_resp_ready_o,
    input  dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i
  );

  modport slave (
    input  dmi_req_valid_o, dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o,
    input  dmi_resp_ready_o,
    output dmi_req_ready_i, dmi_resp_valid_i, dmi_resp_data_i, dmi_resp_resp_i
  );
endinterface

// File: rtl/jtag_dtm_tap.sv
// RISC-V JTAG debug transport module: IEEE 1149.1 TAP controller with
// IDCODE, DTMCS, DMI and BYPASS data registers. DMI scans are turned into
// request/response transactions on the DMI bundle, all in the tck domain.
//
// Ports:
//   tck_i     JTAG clock (also clocks the DMI side)
//   rst_n     asynchronous active-low reset
//   tms_i     test mode select, sampled on tck rising edge
//   tdi_i     test data in, sampled on tck rising edge
//   tdo_o     test data out, updated on tck falling edge
//   tdo_oe_o  high while in Shift-IR / Shift-DR
//   dmi       DMI master modport (request / response handshakes)
//
// Optional feature macro: DTM_DMIHARDRESET_EN
//   When defined, a DTMCS update with bit 17 set aborts any outstanding DMI
//   transaction and clears the sticky error. Otherwise bit 17 is ignored.
module jtag_dtm_tap #(
  parameter logic [31:0] IdcodeValue = 32'h0000_0DB3,
  parameter int unsigned IrLength    = 5,
  parameter int unsigned AddrWidth   = 7
) (
  input  logic           tck_i,
  input  logic           rst_n,
  input  logic           tms_i,
  input  logic           tdi_i,
  output logic           tdo_o,
  output logic           tdo_oe_o,
  jtag_dtm_tap_if.master dmi
);

  localparam int unsigned DrWidth = AddrWidth + 34;

  localparam logic [IrLength-1:0] IR_IDCODE = IrLength'(5'h01);
  localparam logic [IrLength-1:0] IR_DTMCS  = IrLength'(5'h10);
  localparam logic [IrLength-1:0] IR_DMI    = IrLength'(5'h11);

  localparam logic [1:0] ERR_OK   = 2'd0;
  localparam logic [1:0] ERR_FAIL = 2'd2;
  localparam logic [1:0] ERR_BUSY = 2'd3;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  typedef enum logic [3:0] {
    TAP_TLR, TAP_RTI,
    TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR, TAP_UPD_DR,
    TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_WAIT} dmi_state_e;

  typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_DTMCS, SEL_DMI} dr_sel_e;

  tap_state_e           tap_q, tap_d;
  logic [IrLength-1:0]  ir_q, ir_d;
  logic [IrLength-1:0]  ir_sr_q, ir_sr_d;
  logic [DrWidth-1:0]   dr_q, dr_d;
  dmi_state_e           dmi_state_q, dmi_state_d;
  logic [1:0]           err_q, err_d;
  logic [AddrWidth-1:0] req_addr_q, req_addr_d;
  logic [31:0]          req_data_q, req_data_d;
  logic [1:0]           req_op_q, req_op_d;
  logic [31:0]          resp_data_q, resp_data_d;
  logic                 tdo_q, tdo_d;
  logic                 tdo_oe_q, tdo_oe_d;

  dr_sel_e              dr_sel;
  logic                 dmi_busy;
  logic                 err_clear;
  logic [31:0]          dtmcs_capture;
  logic [1:0]           upd_op;
  logic [31:0]          upd_data;
  logic [AddrWidth-1:0] upd_addr;

  // ---------------------------------------------------------------- TAP FSM
  always_comb begin
    tap_d = tap_q;
    case (tap_q)
      TAP_TLR:    tap_d = tms_i ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    tap_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: tap_d = tms_i ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: tap_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  tap_d = tms_i ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: tap_d = tms_i ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  tap_d = tms_i ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: tap_d = tms_i ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: tap_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: tap_d = tms_i ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: tap_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  tap_d = tms_i ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: tap_d = tms_i ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  tap_d = tms_i ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: tap_d = tms_i ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: tap_d = tms_i ? TAP_SEL_DR : TAP_RTI;
      default:    tap_d = TAP_TLR;
    endcase
  end

  // Undefined instruction codes fall through to BYPASS.
  always_comb begin
    case (ir_q)
      IR_IDCODE: dr_sel = SEL_IDCODE;
      IR_DTMCS:  dr_sel = SEL_DTMCS;
      IR_DMI:    dr_sel = SEL_DMI;
      default:   dr_sel = SEL_BYPASS;
    endcase
  end

  assign dmi_busy      = (dmi_state_q != DMI_IDLE);
  assign dtmcs_capture = {14'b0, 1'b0, 1'b0, 1'b0, 3'd1, err_q, 6'(AddrWidth), 4'd1};
  assign upd_op        = dr_q[1:0];
  assign upd_data      = dr_q[33:2];
  assign upd_addr      = dr_q[DrWidth-1:34];

  // ------------------------------------------------ registers and DMI FSM
  always_comb begin
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    dr_d        = dr_q;
    dmi_state_d = dmi_state_q;
    err_d       = err_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;
    resp_data_d = resp_data_q;
    err_clear   = 1'b0;

    // Debug-module side progress of the outstanding transaction.
    case (dmi_state_q)
      DMI_REQ: begin
        if (dmi.dmi_req_ready_i) dmi_state_d = DMI_WAIT;
      end
      DMI_WAIT: begin
        if (dmi.dmi_resp_valid_i) begin
          dmi_state_d = DMI_IDLE;
          resp_data_d = dmi.dmi_resp_data_i;
          // First error wins; a later failure never masks a busy error.
          if (dmi.dmi_resp_resp_i == ERR_FAIL && err_q == ERR_OK) err_d = ERR_FAIL;
        end
      end
      default: ;
    endcase

    // JTAG side actions, taken on the rising edge that leaves each state.
    case (tap_q)
      TAP_CAP_IR: ir_sr_d = IrLength'(1);
      TAP_SH_IR:  ir_sr_d = {tdi_i, ir_sr_q[IrLength-1:1]};
      TAP_UPD_IR: ir_d    = ir_sr_q;
      TAP_CAP_DR: begin
        case (dr_sel)
          SEL_IDCODE: dr_d = DrWidth'(IdcodeValue);
          SEL_DTMCS:  dr_d = DrWidth'(dtmcs_capture);
          SEL_DMI: begin
            // Scanning while a transaction is in flight reports busy and
            // makes it sticky so the debugger knows to back off.
            dr_d = {req_addr_q, resp_data_q, dmi_busy ? ERR_BUSY : err_q};
            if (dmi_busy) err_d = ERR_BUSY;
          end
          default:    dr_d = '0;
        endcase
      end
      TAP_SH_DR: begin
        case (dr_sel)
          SEL_IDCODE, SEL_DTMCS: dr_d = DrWidth'({tdi_i, dr_q[31:1]});
          SEL_DMI:               dr_d = {tdi_i, dr_q[DrWidth-1:1]};
          default:               dr_d = DrWidth'(tdi_i);
        endcase
      end
      TAP_UPD_DR: begin
        if (dr_sel == SEL_DMI) begin
          if (upd_op == OP_READ || upd_op == OP_WRITE) begin
            if (dmi_busy) begin
              err_d = ERR_BUSY;
            end else if (err_q == ERR_OK) begin
              dmi_state_d = DMI_REQ;
              req_addr_d  = upd_addr;
              req_data_d  = upd_data;
              req_op_d    = upd_op;
            end
          end
        end else if (dr_sel == SEL_DTMCS) begin
          err_clear = dr_q[16];
`ifdef DTM_DMIHARDRESET_EN
          if (dr_q[17]) begin
            err_clear   = 1'b1;
            dmi_state_d = DMI_IDLE;
          end
`endif
        end
      end
      default: ;
    endcase

    // dmireset has the last word over any error raised in the same cycle.
    if (err_clear) err_d = ERR_OK;

    if (tap_d == TAP_TLR) ir_d = IR_IDCODE;
  end

  always_ff @(posedge tck_i or negedge rst_n) begin
    if (!rst_n) begin
      tap_q       <= TAP_TLR;
      ir_q        <= IR_IDCODE;
      ir_sr_q     <= '0;
      dr_q        <= '0;
      dmi_state_q <= DMI_IDLE;
      err_q       <= ERR_OK;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
      resp_data_q <= '0;
    end else begin
      tap_q       <= tap_d;
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      dr_q        <= dr_d;
      dmi_state_q <= dmi_state_d;
      err_q       <= err_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_op_q    <= req_op_d;
      resp_data_q <= resp_data_d;
    end
  end

  // ------------------------------------------------------ falling-edge TDO
  always_comb begin
    tdo_d    = (tap_q == TAP_SH_IR) ? ir_sr_q[0] : dr_q[0];
    tdo_oe_d = (tap_q == TAP_SH_IR) || (tap_q == TAP_SH_DR);
  end

  always_ff @(negedge tck_i or negedge rst_n) begin
    if (!rst_n) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_oe_q <= tdo_oe_d;
    end
  end

  assign tdo_o    = tdo_q;
  assign tdo_oe_o = tdo_oe_q;

  // Request fields come straight from registers loaded only at launch, so
  // they cannot move while valid is high. Valid is decoded from state so an
  // asynchronous reset drops it at once.
  assign dmi.dmi_req_valid_o  = (dmi_state_q == DMI_REQ);
  assign dmi.dmi_req_addr_o   = req_addr_q;
  assign dmi.dmi_req_data_o   = req_data_q;
  assign dmi.dmi_req_op_o     = req_op_q;
  assign dmi.dmi_resp_ready_o = 1'b1;

endmodule

// File: tb/tb_jtag_dtm_tap.sv
module tb_jtag_dtm_tap;

  localparam logic [4:0] IR_DTMCS = 5'h10;
  localparam logic [4:0] IR_DMI   = 5'h11;
`ifdef DTM_DMIHARDRESET_EN
  localparam bit HARD_EN = 1'b1;
`else
  localparam bit HARD_EN = 1'b0;
`endif

  logic tck_i = 1'b0;
  logic rst_n;
  logic tms_i;
  logic tdi_i;
  logic tdo_o;
  logic tdo_oe_o;

  jtag_dtm_tap_if #(.AddrWidth(7)) dmi_bus ();

  jtag_dtm_tap #(
    .IdcodeValue(32'h0000_0DB3),
    .IrLength   (5),
    .AddrWidth  (7)
  ) dut (
    .tck_i   (tck_i),
    .rst_n   (rst_n),
    .tms_i   (tms_i),
    .tdi_i   (tdi_i),
    .tdo_o   (tdo_o),
    .tdo_oe_o(tdo_oe_o),
    .dmi     (dmi_bus)
  );

  always #5 tck_i = ~tck_i;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model of the DTM as seen by the debugger.
  logic [1:0]  m_err;
  logic        m_busy;
  logic [6:0]  m_last_addr;
  logic [31:0] m_resp_data;
  logic        shift_oe;

  task automatic model_reset();
    m_err = 2'd0; m_busy = 1'b0; m_last_addr = 7'd0; m_resp_data = 32'd0;
  endtask

  // One tck cycle; inputs change just after the falling edge, tdo is
  // sampled 1 ns after the next falling edge.
  task automatic step(input logic tms, input logic tdi, output logic tdo);
    tms_i = tms;
    tdi_i = tdi;
    @(posedge tck_i);
    @(negedge tck_i);
    #1;
    tdo = tdo_o;
  endtask

  // From Run-Test/Idle, scan n DR bits and return to Run-Test/Idle.
  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic o;
    dout = '0;
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    shift_oe = tdo_oe_o;
    for (int i = 0; i < n; i++) begin
      dout[i] = o;
      step(logic'(i == n - 1), din[i], o);
    end
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
  endtask

  task automatic set_ir(input logic [4:0] v);
    logic o;
    logic [4:0] cap;
    step(1'b1, 1'b0, o);
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) begin
      cap[i] = o;
      step(logic'(i == 4), v[i], o);
    end
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    checks++;
    if (cap !== 5'b00001) begin
      errors++;
      $display("FAIL ir_capture: got %b expected 00001", cap);
    end
    $display("ir scan: loaded %h", v);
  endtask

  task automatic dtmcs_scan(input logic [31:0] din);
    logic [63:0] dout;
    logic [31:0] exp_cap;
    exp_cap = 32'h0000_1071 | ({30'd0, m_err} << 10);
    scan_dr(32, {32'd0, din}, dout);
    checks++;
    if (dout[31:0] !== exp_cap) begin
      errors++;
      $display("FAIL dtmcs_capture: got %h expected %h", dout[31:0], exp_cap);
    end
    if (din[16]) m_err = 2'd0;
    if (HARD_EN && din[17]) begin m_err = 2'd0; m_busy = 1'b0; end
    $display("dtmcs scan: wrote %h captured %h", din, dout[31:0]);
  endtask

  task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                          output logic launched);
    logic [63:0] dout;
    logic [40:0] exp_cap;
    exp_cap = {m_last_addr, m_resp_data, (m_busy ? 2'd3 : m_err)};
    if (m_busy) m_err = 2'd3;
    scan_dr(41, {23'd0, a, d, op}, dout);
    checks++;
    if (dout[40:0] !== exp_cap) begin
      errors++;
      $display("FAIL dmi_capture: got %h expected %h", dout[40:0], exp_cap);
    end
    launched = 1'b0;
    if (op == 2'd1 || op == 2'd2) begin
      if (m_busy) m_err = 2'd3;
      else if (m_err == 2'd0) begin
        launched = 1'b1; m_busy = 1'b1; m_last_addr = a;
      end
    end
    checks++;
    if (dmi_bus.dmi_req_valid_o !== launched) begin
      errors++;
      $display("FAIL req_valid: got %b expected %b", dmi_bus.dmi_req_valid_o, launched);
    end
    if (launched) begin
      checks++;
      if ({dmi_bus.dmi_req_addr_o, dmi_bus.dmi_req_data_o, dmi_bus.dmi_req_op_o} !== {a, d, op}) begin
        errors++;
        $display("FAIL req_fields: got %h/%h/%h expected %h/%h/%h", dmi_bus.dmi_req_addr_o,
                 dmi_bus.dmi_req_data_o, dmi_bus.dmi_req_op_o, a, d, op);
      end
    end
    $display("dmi scan: addr=%h data=%h op=%0d captured=%h launched=%b", a, d, op, dout[40:0], launched);
  endtask

  // DM holds ready low for lat cycles, then accepts.
  task automatic dm_accept(input int lat);
    logic o;
    for (int i = 0; i < lat; i++) begin
      step(1'b0, 1'b0, o);
      checks++;
      if (dmi_bus.dmi_req_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL valid_hold: got %b expected 1", dmi_bus.dmi_req_valid_o);
      end
    end
    dmi_bus.dmi_req_ready_i = 1'b1;
    step(1'b0, 1'b0, o);
    dmi_bus.dmi_req_ready_i = 1'b0;
    checks++;
    if (dmi_bus.dmi_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL valid_drop: got %b expected 0", dmi_bus.dmi_req_valid_o);
    end
  endtask

  task automatic dm_respond(input int lat, input logic [31:0] d, input logic [1:0] r);
    logic o;
    for (int i = 0; i < lat; i++) step(1'b0, 1'b0, o);
    dmi_bus.dmi_resp_valid_i = 1'b1;
    dmi_bus.dmi_resp_data_i  = d;
    dmi_bus.dmi_resp_resp_i  = r;
    step(1'b0, 1'b0, o);
    dmi_bus.dmi_resp_valid_i = 1'b0;
    m_resp_data = d;
    if (r == 2'd2 && m_err == 2'd0) m_err = 2'd2;
    m_busy = 1'b0;
    $display("dm response: data=%h resp=%0d", d, r);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    logic o;
    rst_n = 1'b0;
    #23;
    checks++;
    if ({dmi_bus.dmi_req_valid_o, dmi_bus.dmi_resp_ready_o, tdo_o, tdo_oe_o} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0100",
               {dmi_bus.dmi_req_valid_o, dmi_bus.dmi_resp_ready_o, tdo_o, tdo_oe_o});
    end
    @(negedge tck_i); #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, o);
  endtask

  task automatic test_idcode();
    logic [63:0] dout;
    scan_dr(32, 64'd0, dout);
    checks++;
    if (dout[31:0] !== 32'h0000_0DB3) begin
      errors++;
      $display("FAIL idcode: got %h expected 00000db3", dout[31:0]);
    end
    checks++;
    if ({shift_oe, tdo_oe_o} !== 2'b10) begin
      errors++;
      $display("FAIL tdo_oe: got %b expected 10", {shift_oe, tdo_oe_o});
    end
    $display("idcode scan: %h", dout[31:0]);
  endtask

  task automatic test_dtmcs();
    set_ir(IR_DTMCS);
    dtmcs_scan(32'd0);
  endtask

  task automatic test_bypass();
    logic [63:0] dout;
    logic [8:0]  pat;
    logic [4:0]  codes [2] = '{5'h1F, 5'h05};
    for (int k = 0; k < 2; k++) begin
      set_ir(codes[k]);
      pat = 9'($urandom);
      scan_dr(9, {55'd0, pat}, dout);
      checks++;
      if (dout[8:0] !== {pat[7:0], 1'b0}) begin
        errors++;
        $display("FAIL bypass: got %b expected %b", dout[8:0], {pat[7:0], 1'b0});
      end
      $display("bypass scan: ir=%h in=%b out=%b", codes[k], pat, dout[8:0]);
    end
  endtask

  task automatic test_tlr();
    logic o;
    logic [63:0] dout;
    set_ir(IR_DTMCS);
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    scan_dr(32, 64'd0, dout);
    checks++;
    if (dout[31:0] !== 32'h0000_0DB3) begin
      errors++;
      $display("FAIL tlr_idcode: got %h expected 00000db3", dout[31:0]);
    end
    $display("tlr then dr scan: %h", dout[31:0]);
  endtask

  task automatic test_dmi_write();
    logic l;
    set_ir(IR_DMI);
    dmi_scan(7'h10, 32'h0000_0001, 2'd2, l);
    dm_accept(3);
    dm_respond(1, 32'd0, 2'd0);
    dmi_scan(7'h00, 32'd0, 2'd0, l);
  endtask

  task automatic test_dmi_read();
    logic l;
    dmi_scan(7'h38, 32'd0, 2'd1, l);
    dm_accept(0);
    dm_respond(2, 32'h2004_0000, 2'd0);
    dmi_scan(7'h00, 32'd0, 2'd0, l);
  endtask

  task automatic test_busy();
    logic l;
    dmi_scan(7'h11, 32'd0, 2'd1, l);
    dm_accept(1);
    dmi_scan(7'h12, 32'hDEAD_BEEF, 2'd2, l);
    dm_respond(0, $urandom, 2'd0);
    set_ir(IR_DTMCS);
    dtmcs_scan(32'h0001_0000);
    dtmcs_scan(32'd0);
    set_ir(IR_DMI);
    dmi_scan(7'h00, 32'd0, 2'd0, l);
  endtask

  task automatic test_fail();
    logic l;
    dmi_scan(7'h20, 32'd0, 2'd1, l);
    dm_accept(0);
    dm_respond(0, 32'h1234_5678, 2'd2);
    dmi_scan(7'h21, 32'd0, 2'd1, l);
    dmi_scan(7'h00, 32'd0, 2'd0, l);
    set_ir(IR_DTMCS);
    dtmcs_scan(32'h0001_0000);
    set_ir(IR_DMI);
    dmi_scan(7'h22, 32'hCAFE_0001, 2'd2, l);
    if (l) begin dm_accept(1); dm_respond(0, 32'd0, 2'd0); end
  endtask

  task automatic test_hardreset();
    logic l;
    dmi_scan(7'h15, $urandom, 2'd1, l);
    dm_accept(0);
    set_ir(IR_DTMCS);
    dtmcs_scan(32'h0002_0000);
    set_ir(IR_DMI);
    dmi_scan(7'h00, 32'd0, 2'd0, l);
    if (m_busy) dm_respond(0, $urandom, 2'd0);
    if (m_err != 2'd0) begin
      set_ir(IR_DTMCS);
      dtmcs_scan(32'h0001_0000);
      set_ir(IR_DMI);
    end
    dmi_scan(7'h16, $urandom, 2'd2, l);
    if (l) begin dm_accept(0); dm_respond(0, $urandom, 2'd0); end
  endtask

  task automatic test_reset_mid();
    logic l;
    logic o;
    dmi_scan(7'h30, $urandom, 2'd2, l);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dmi_bus.dmi_req_valid_o, dmi_bus.dmi_resp_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid: got %b expected 01", {dmi_bus.dmi_req_valid_o, dmi_bus.dmi_resp_ready_o});
    end
    @(negedge tck_i); #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b0, o);
    set_ir(IR_DMI);
    dmi_scan(7'h00, 32'd0, 2'd0, l);
  endtask

  task automatic test_random();
    logic l;
    logic l2;
    for (int it = 0; it < 24; it++) begin
      if (m_err != 2'd0 && $urandom_range(0, 1) == 1) begin
        set_ir(IR_DTMCS);
        dtmcs_scan(32'h0001_0000);
        set_ir(IR_DMI);
      end
      dmi_scan(7'($urandom), $urandom, 2'($urandom_range(0, 3)), l);
      if (l) begin
        dm_accept(int'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) == 0)
          dmi_scan(7'($urandom), $urandom, 2'($urandom_range(0, 3)), l2);
        dm_respond(int'($urandom_range(0, 3)), $urandom,
                   ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0);
      end
    end
  endtask

  initial begin
    tms_i = 1'b1;
    tdi_i = 1'b0;
    rst_n = 1'b0;
    dmi_bus.dmi_req_ready_i  = 1'b0;
    dmi_bus.dmi_resp_valid_i = 1'b0;
    dmi_bus.dmi_resp_data_i  = 32'd0;
    dmi_bus.dmi_resp_resp_i  = 2'd0;
    model_reset();

    test_reset();
    test_idcode();
    test_dtmcs();
    test_bypass();
    test_tlr();
    test_dmi_write();
    test_dmi_read();
    test_busy();
    test_fail();
    test_hardreset();
    test_reset_mid();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
